ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
Consumer stage directly downstream of the PS/2 keyboard receiver FIFO. Pops raw scan-code bytes over the receiver's ready/nextdata_n handshake. Decodes E0 (extended) and F0 (break) prefixes into single key events, suppresses typematic repeats, and tracks shift/caps state. Produces ASCII plus a press counter for the seven-segment/display logic.

Parameters:
COUNT_W, 8, width of press_count; wraps modulo 2^COUNT_W

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
ready  in  1  receiver FIFO non-empty; data valid while high
data  in  8  scan-code byte at FIFO head
nextdata_n  out  1  active-low pop strobe to receiver, one cycle per byte
key_valid  out  1  one-cycle pulse: key event fields valid
key_code  out  8  scan code of event (prefixes stripped)
key_ext  out  1  event was E0-prefixed
key_make  out  1  1 = make (press), 0 = break (release)
key_repeat  out  1  make of code already held (typematic)
key_ascii  out  8  ASCII of key_code; 0x00 if unmapped/extended
key_held  out  1  a non-released key is held
shift  out  1  left (12) or right (59) shift held, non-extended
caps  out  1  caps-lock toggle state
press_count  out  COUNT_W  count of non-repeat make events

Behaviour:
- Reset (clr=1, async): state IDLE, nextdata_n=1, all other outputs 0, prefix flags/held register cleared. Reset mid-byte drops that byte's processing; the pop may or may not have occurred.
- FSM: IDLE -> POP -> EMIT -> GAP -> IDLE.
  - IDLE: if ready=1, latch data into byte_r, go POP; else stay.
  - POP: nextdata_n=0 for exactly this cycle.
  - EMIT: decode byte_r, update registers; key_valid=1 this cycle iff event.
  - GAP: one idle cycle so receiver ready/data settle after pop; ready is never sampled in GAP.
- Latency: key_valid high 3 cycles after the IDLE cycle sampling ready=1; minimum 4 cycles per byte.
- Decode of byte_r in EMIT:
  - 0xE0: ext_pend=1, no event.
  - 0xF0: brk_pend=1, no event (ext_pend kept).
  - 0x00 or 0xFF (keyboard error): clear both pending flags, no event.
  - Any other byte: event with key_code=byte_r, key_ext=ext_pend, key_make=~brk_pend; then clear both flags.
- Event fields hold between events; key_valid is a pulse only.
- Held tracking: held register {code,ext,valid}.
  - Make matching a valid held entry: key_repeat=1.
  - Other make: load held, key_repeat=0.
  - Break matching held: clear valid.
  - Break of a different key: no change.
  - key_held = held valid.
- Shift: set on make, clear on break of non-extended 0x12 or 0x59; tracks each side separately; shift = OR.
- Caps: toggles on non-repeat non-extended make of 0x58.
- ASCII (non-extended make or break, else 0x00):
  - A-Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Letters uppercase iff shift XOR caps (state before this event).
  - 0-9: 45 16 1E 26 25 2E 36 3D 3E 46, unaffected by shift.
  - 0x29 -> 0x20; 0x5A -> 0x0D; others -> 0x00.
- press_count: +1 on every make with key_repeat=0 (including modifiers); wraps to 0.
- ready dropping between IDLE sample and POP has no effect; the latched byte is processed.

Test Plan:
- Reset, then ready=1 data=0x1C, receiver advancing on pop:
  - exactly one nextdata_n=0 cycle.
  - key_valid 3 cycles after sample with code=0x1C, make=1, ascii=0x61.
  - press_count=1, key_held=1.
- Byte stream 1C,1C,1C,F0,1C:
  - three makes, repeat=0,1,1.
  - one break, make=0.
  - press_count=1, key_held=0.
- Stream 12,1C,F0,1C,F0,12 then 58,F0,58,1C:
  - first A ascii=0x41, shift=1 then 0.
  - caps=1 after 58; final A ascii=0x41.
  - press_count=4.
- Stream E0,75,E0,F0,75:
  - make code=0x75, ext=1, ascii=0x00.
  - break code=0x75, ext=1, make=0.
  - no event on prefix bytes.
- Stream F0,00,16: 00 clears break flag; event code=0x16, make=1, ascii=0x31.
- Assert clr during POP of 0x1C: all outputs 0 immediately, nextdata_n=1. After release, next byte 0x29 decodes normally, ascii=0x20, press_count=1.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code consumer: pops bytes from the receiver FIFO and folds E0/F0
// prefixes into key events with repeat suppression, shift/caps and ASCII.
module ps2_scancode_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ready,
  input  logic [7:0]         data,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_make,
  output logic               key_repeat,
  output logic [7:0]         key_ascii,
  output logic               key_held,
  output logic               shift,
  output logic               caps,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_EMIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t               state_r;
  logic [7:0]           byte_r;
  logic                 ext_pend_r;
  logic                 brk_pend_r;
  logic [7:0]           held_code_r;
  logic                 held_ext_r;
  logic                 held_valid_r;
  logic                 lshift_r;
  logic                 rshift_r;
  logic                 shift_r;
  logic                 caps_r;
  logic [COUNT_W-1:0]   press_count_r;
  logic                 nextdata_n_r;
  logic                 key_valid_r;
  logic [7:0]           key_code_r;
  logic                 key_ext_r;
  logic                 key_make_r;
  logic                 key_repeat_r;
  logic [7:0]           key_ascii_r;

  logic                 make_s;
  logic                 match_s;
  logic                 repeat_s;
  logic [7:0]           ascii_s;
  logic                 lshift_s;
  logic                 rshift_s;

  // Set-1-free scan-code set 2 to ASCII; letters fold to uppercase on request.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] base;
    case (code)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
      8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
      8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
      8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
      8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
      8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
      8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
      8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
      8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
      8'h46: base = 8'h39;
      8'h29: base = 8'h20;  8'h5A: base = 8'h0D;
      default: base = 8'h00;
    endcase
    if (upper && (base >= 8'h61) && (base <= 8'h7A)) begin
      scan_to_ascii = base - 8'h20;
    end else begin
      scan_to_ascii = base;
    end
  endfunction

  // Event decode of the latched byte against pending prefixes and held key.
  always_comb begin
    make_s   = ~brk_pend_r;
    match_s  = held_valid_r && (held_code_r == byte_r) && (held_ext_r == ext_pend_r);
    repeat_s = make_s && match_s;
    if (ext_pend_r) begin
      ascii_s = 8'h00;
    end else begin
      ascii_s = scan_to_ascii(byte_r, shift_r ^ caps_r);
    end
    if (!ext_pend_r && (byte_r == 8'h12)) begin
      lshift_s = make_s;
    end else begin
      lshift_s = lshift_r;
    end
    if (!ext_pend_r && (byte_r == 8'h59)) begin
      rshift_s = make_s;
    end else begin
      rshift_s = rshift_r;
    end
  end

  // Pop/decode sequencer and all event/state registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r       <= ST_IDLE;
      byte_r        <= 8'h00;
      ext_pend_r    <= 1'b0;
      brk_pend_r    <= 1'b0;
      held_code_r   <= 8'h00;
      held_ext_r    <= 1'b0;
      held_valid_r  <= 1'b0;
      lshift_r      <= 1'b0;
      rshift_r      <= 1'b0;
      shift_r       <= 1'b0;
      caps_r        <= 1'b0;
      press_count_r <= '0;
      nextdata_n_r  <= 1'b1;
      key_valid_r   <= 1'b0;
      key_code_r    <= 8'h00;
      key_ext_r     <= 1'b0;
      key_make_r    <= 1'b0;
      key_repeat_r  <= 1'b0;
      key_ascii_r   <= 8'h00;
    end else begin
      key_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ready) begin
            byte_r       <= data;
            nextdata_n_r <= 1'b0;
            state_r      <= ST_POP;
          end
        end
        ST_POP: begin
          nextdata_n_r <= 1'b1;
          state_r      <= ST_EMIT;
        end
        ST_EMIT: begin
          state_r <= ST_GAP;
          case (byte_r)
            8'hE0: ext_pend_r <= 1'b1;
            8'hF0: brk_pend_r <= 1'b1;
            8'h00, 8'hFF: begin
              ext_pend_r <= 1'b0;
              brk_pend_r <= 1'b0;
            end
            default: begin
              key_valid_r  <= 1'b1;
              key_code_r   <= byte_r;
              key_ext_r    <= ext_pend_r;
              key_make_r   <= make_s;
              key_repeat_r <= repeat_s;
              key_ascii_r  <= ascii_s;
              ext_pend_r   <= 1'b0;
              brk_pend_r   <= 1'b0;
              lshift_r     <= lshift_s;
              rshift_r     <= rshift_s;
              shift_r      <= lshift_s | rshift_s;
              if (make_s && !match_s) begin
                held_code_r   <= byte_r;
                held_ext_r    <= ext_pend_r;
                held_valid_r  <= 1'b1;
                press_count_r <= press_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                if (!ext_pend_r && (byte_r == 8'h58)) begin
                  caps_r <= ~caps_r;
                end
              end else if (!make_s && match_s) begin
                held_valid_r <= 1'b0;
              end
            end
          endcase
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          nextdata_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign nextdata_n  = nextdata_n_r;
  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign key_ext     = key_ext_r;
  assign key_make    = key_make_r;
  assign key_repeat  = key_repeat_r;
  assign key_ascii   = key_ascii_r;
  assign key_held    = held_valid_r;
  assign shift       = shift_r;
  assign caps        = caps_r;
  assign press_count = press_count_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a linear byte script with
// hand-computed expected event fields.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clr;
  logic       ready;
  logic [7:0] data;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_repeat;
  logic [7:0] key_ascii;
  logic       key_held;
  logic       shift;
  logic       caps;
  logic [7:0] press_count;
  logic [30:0] all_outs;

  int total = 0;
  int bad   = 0;
  logic ev;

  ps2_scancode_decoder #(.COUNT_W(8)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_make(key_make), .key_repeat(key_repeat), .key_ascii(key_ascii),
    .key_held(key_held), .shift(shift), .caps(caps), .press_count(press_count)
  );

  always #5 clk = ~clk;

  assign all_outs = {key_valid, key_code, key_ext, key_make, key_repeat,
                     key_ascii, key_held, shift, caps, press_count};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1; ready = 1'b0; data = 8'h00;
    @(negedge clk);
    check("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("rst_outs", {1'b0, all_outs}, 32'd0);
    clr = 1'b0;
  endtask

  // Present one byte, let the receiver advance on the pop, return whether an event fired.
  task automatic send(input logic [7:0] b, output logic got);
    int n;
    @(negedge clk);
    ready = 1'b1; data = b; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nextdata_n !== 1'b0 && n < 8);
    check("pop_seen", {31'd0, nextdata_n}, 32'd0);
    check("pop_latency", n, 32'd1);
    ready = 1'b0; data = 8'hFF;
    @(negedge clk);
    check("pop_once", {31'd0, nextdata_n}, 32'd1);
    check("valid_early", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    got = key_valid;
    @(negedge clk);
    check("valid_pulse", {31'd0, key_valid}, 32'd0);
  endtask

  task automatic send_ev(input string tag, input logic [7:0] b, input logic exp_ev);
    logic g;
    send(b, g);
    check(tag, {31'd0, g}, {31'd0, exp_ev});
  endtask

  initial begin
    clr = 1'b1; ready = 1'b0; data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("rst_outs", {1'b0, all_outs}, 32'd0);
    clr = 1'b0;

    // single make of A
    send_ev("t1_evt", 8'h1C, 1'b1);
    check("t1_code", key_code, 32'h1C);
    check("t1_make", key_make, 32'd1);
    check("t1_ext", key_ext, 32'd0);
    check("t1_rep", key_repeat, 32'd0);
    check("t1_ascii", key_ascii, 32'h61);
    check("t1_count", press_count, 32'd1);
    check("t1_held", key_held, 32'd1);

    // typematic repeats then release
    do_reset();
    send_ev("t2_e1", 8'h1C, 1'b1);
    check("t2_rep1", key_repeat, 32'd0);
    send_ev("t2_e2", 8'h1C, 1'b1);
    check("t2_rep2", key_repeat, 32'd1);
    send_ev("t2_e3", 8'h1C, 1'b1);
    check("t2_rep3", key_repeat, 32'd1);
    check("t2_make3", key_make, 32'd1);
    send_ev("t2_f0", 8'hF0, 1'b0);
    send_ev("t2_brk", 8'h1C, 1'b1);
    check("t2_brk_make", key_make, 32'd0);
    check("t2_brk_rep", key_repeat, 32'd0);
    check("t2_count", press_count, 32'd1);
    check("t2_held", key_held, 32'd0);

    // shift and caps
    do_reset();
    send_ev("t3_lsh", 8'h12, 1'b1);
    check("t3_shift_on", shift, 32'd1);
    send_ev("t3_a", 8'h1C, 1'b1);
    check("t3_ascii_shift", key_ascii, 32'h41);
    send_ev("t3_f0a", 8'hF0, 1'b0);
    send_ev("t3_abrk", 8'h1C, 1'b1);
    send_ev("t3_f0b", 8'hF0, 1'b0);
    send_ev("t3_lshbrk", 8'h12, 1'b1);
    check("t3_shift_off", shift, 32'd0);
    send_ev("t3_caps", 8'h58, 1'b1);
    check("t3_caps_on", caps, 32'd1);
    check("t3_caps_ascii", key_ascii, 32'h00);
    send_ev("t3_f0c", 8'hF0, 1'b0);
    send_ev("t3_capsbrk", 8'h58, 1'b1);
    check("t3_caps_hold", caps, 32'd1);
    send_ev("t3_a2", 8'h1C, 1'b1);
    check("t3_ascii_caps", key_ascii, 32'h41);
    check("t3_count", press_count, 32'd4);

    // extended key make and break
    do_reset();
    send_ev("t4_e0a", 8'hE0, 1'b0);
    send_ev("t4_mk", 8'h75, 1'b1);
    check("t4_mk_code", key_code, 32'h75);
    check("t4_mk_ext", key_ext, 32'd1);
    check("t4_mk_make", key_make, 32'd1);
    check("t4_mk_ascii", key_ascii, 32'h00);
    send_ev("t4_e0b", 8'hE0, 1'b0);
    send_ev("t4_f0", 8'hF0, 1'b0);
    send_ev("t4_brk", 8'h75, 1'b1);
    check("t4_brk_code", key_code, 32'h75);
    check("t4_brk_ext", key_ext, 32'd1);
    check("t4_brk_make", key_make, 32'd0);
    check("t4_held", key_held, 32'd0);

    // error byte discards a pending break
    do_reset();
    send_ev("t5_f0", 8'hF0, 1'b0);
    send_ev("t5_err", 8'h00, 1'b0);
    send_ev("t5_key", 8'h16, 1'b1);
    check("t5_code", key_code, 32'h16);
    check("t5_make", key_make, 32'd1);
    check("t5_ascii", key_ascii, 32'h31);
    check("t5_count", press_count, 32'd1);

    // clear asserted while the pop strobe is low
    @(negedge clk);
    ready = 1'b1; data = 8'h1C;
    @(negedge clk);
    check("t6_pop", {31'd0, nextdata_n}, 32'd0);
    clr = 1'b1;
    #1;
    check("t6_nextdata_n", {31'd0, nextdata_n}, 32'd1);
    check("t6_outs", {1'b0, all_outs}, 32'd0);
    ready = 1'b0; data = 8'h00;
    @(negedge clk);
    clr = 1'b0;
    send_ev("t6_space", 8'h29, 1'b1);
    check("t6_ascii", key_ascii, 32'h20);
    check("t6_make", key_make, 32'd1);
    check("t6_count", press_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
